// File: rtl/tff_mod_counter_if.sv
// Control and status bundle for the modulo counter.
// The master drives the count controls; the slave is the counter itself.
interface tff_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/tff_mod_counter.sv
// Up/down modulo counter on a bank of T flip-flops.
// Supports parallel load with clamp, wrap or saturate at range ends.
module tff_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input logic                clk,
    input logic                rst,
    tff_mod_counter_if.slave   bus
);
    localparam longint unsigned RANGE = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam bit               SAT  = (SATURATE != 0);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > longint'(RANGE)) begin : g_bad_modulus
            $error("tff_mod_counter: MODULUS out of range 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] tog;
    logic             wrap_nxt;
    logic             wrap_q;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);

    // Next count and wrap event: load beats enable, enable beats hold.
    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!at_max) begin
                    nxt = q + 1'b1;
                end else if (!SAT) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    nxt = q - 1'b1;
                end else if (!SAT) begin
                    nxt      = MAX;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Each state bit toggles exactly where the next count differs.
    assign tog = q ^ nxt;

    // T flip-flop bank with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tog[i]) q[i] <= ~q[i];
            end
        end
    end

    // Registered one-cycle wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_nxt;
    end

    assign bus.count = q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = (bus.up & at_max) | (~bus.up & at_zero);
endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter: three instances cover
// wrap mode (mod 10), saturate mode (mod 10) and the mod-2 edge case.
module tb_tff_mod_counter;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;

    always #5 clk = ~clk;

    tff_mod_counter_if #(.WIDTH(4)) if0 ();
    tff_mod_counter_if #(.WIDTH(4)) if1 ();
    tff_mod_counter_if #(.WIDTH(4)) if2 ();

    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0.slave)
    );
    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(if1.slave)
    );
    tff_mod_counter #(.WIDTH(4), .MODULUS(2), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst2), .bus(if2.slave)
    );

    typedef struct {
        int       id;
        string    tag;
        logic [3:0] count;
        logic     wrap;
        logic     tc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic check(string name, int id, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d",
                     name, id, got, want);
        end
    endtask

    // Monitor: after every edge, compare against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        logic [3:0] c;
        logic w, t;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                0: begin c = if0.count; w = if0.wrap; t = if0.tc; end
                1: begin c = if1.count; w = if1.wrap; t = if1.tc; end
                default: begin c = if2.count; w = if2.wrap; t = if2.tc; end
            endcase
            check({e.tag, ".count"}, e.id, int'(c), int'(e.count));
            check({e.tag, ".wrap"},  e.id, int'(w), int'(e.wrap));
            check({e.tag, ".tc"},    e.id, int'(t), int'(e.tc));
        end
    end

    task automatic idle_all();
        rst0 = 0; rst1 = 0; rst2 = 0;
        if0.en = 0; if0.up = 1; if0.load = 0; if0.load_val = '0;
        if1.en = 0; if1.up = 1; if1.load = 0; if1.load_val = '0;
        if2.en = 0; if2.up = 1; if2.load = 0; if2.load_val = '0;
    endtask

    // Drive one cycle of stimulus on one instance and queue its expectation.
    task automatic step(input int id, input string tag,
                        input bit r, input bit e, input bit u,
                        input bit l, input logic [3:0] lv,
                        input logic [3:0] ec, input bit ew, input bit et);
        exp_t x;
        @(negedge clk);
        idle_all();
        case (id)
            0: begin rst0 = r; if0.en = e; if0.up = u;
                     if0.load = l; if0.load_val = lv; end
            1: begin rst1 = r; if1.en = e; if1.up = u;
                     if1.load = l; if1.load_val = lv; end
            default: begin rst2 = r; if2.en = e; if2.up = u;
                     if2.load = l; if2.load_val = lv; end
        endcase
        x.id = id; x.tag = tag;
        x.count = ec; x.wrap = ew; x.tc = et;
        sbq.push_back(x);
    endtask

    logic [3:0] up_cnt [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    bit up_wrap [12] = '{0,0,0,0,0,0,0,0,0,1,0,0};
    bit up_tc   [12] = '{0,0,0,0,0,0,0,0,1,0,0,0};

    initial begin
        idle_all();
        rst0 = 1; rst1 = 1; rst2 = 1;
        @(negedge clk);

        // Reset dominates en and load.
        step(0, "rst_a", 1, 1, 1, 1, 4'd7, 4'd0, 0, 0);
        step(0, "rst_b", 1, 1, 1, 1, 4'd7, 4'd0, 0, 0);

        // Count up through the wrap.
        for (int i = 0; i < 12; i++)
            step(0, "up", 0, 1, 1, 0, 4'd0, up_cnt[i], up_wrap[i], up_tc[i]);

        // Count down from zero wraps to 9.
        step(0, "rst_c", 1, 0, 0, 0, 4'd0, 4'd0, 0, 1);
        step(0, "dn_wrap", 0, 1, 0, 0, 4'd0, 4'd9, 1, 0);
        step(0, "dn", 0, 1, 0, 0, 4'd0, 4'd8, 0, 0);

        // Load clamps and beats en.
        step(0, "ld_clamp", 0, 1, 1, 1, 4'd12, 4'd9, 0, 1);
        step(0, "ld_3", 0, 1, 1, 1, 4'd3, 4'd3, 0, 0);

        // Direction change and hold.
        step(0, "dir_up", 0, 1, 1, 0, 4'd0, 4'd4, 0, 0);
        step(0, "dir_dn", 0, 1, 0, 0, 4'd0, 4'd3, 0, 0);
        step(0, "hold", 0, 0, 0, 0, 4'd0, 4'd3, 0, 0);

        // Reset in the wrap cycle.
        step(0, "ld_9", 0, 0, 1, 1, 4'd9, 4'd9, 0, 1);
        step(0, "wrap9", 0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        step(0, "rst_wrap", 1, 1, 1, 0, 4'd0, 4'd0, 0, 0);

        // Saturating instance.
        step(1, "s_rst", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0);
        step(1, "s_ld9", 0, 0, 1, 1, 4'd9, 4'd9, 0, 1);
        for (int i = 0; i < 3; i++)
            step(1, "s_hold_top", 0, 1, 1, 0, 4'd0, 4'd9, 0, 1);
        step(1, "s_dn", 0, 1, 0, 0, 4'd0, 4'd8, 0, 0);
        step(1, "s_ld0", 0, 0, 0, 1, 4'd0, 4'd0, 0, 1);
        step(1, "s_hold_bot", 0, 1, 0, 0, 4'd0, 4'd0, 0, 1);

        // Modulus 2: back-to-back wraps, reset in wrap cycle.
        step(2, "m2_rst", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0);
        step(2, "m2_a", 0, 1, 1, 0, 4'd0, 4'd1, 0, 1);
        step(2, "m2_b", 0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        step(2, "m2_c", 0, 1, 1, 0, 4'd0, 4'd1, 0, 1);
        step(2, "m2_d", 0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        step(2, "m2_rstw", 1, 1, 1, 0, 4'd0, 4'd0, 0, 0);
        step(2, "m2_e", 0, 1, 1, 0, 4'd0, 4'd1, 0, 1);
        step(2, "m2_dn", 0, 1, 0, 0, 4'd0, 4'd0, 0, 1);
        step(2, "m2_dnw", 0, 1, 0, 0, 4'd0, 4'd1, 1, 0);
        step(2, "m2_ld", 0, 0, 1, 1, 4'd5, 4'd1, 0, 1);

        @(negedge clk);
        idle_all();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
